me_stall_mem: RTL and testbench

ME_STALL_MEM -- requirements
Module: me_stall_mem

---
 rtl/me_stall_mem_pkg.sv | 6 +
 rtl/me_stall_mem_ram.sv | 15 +
 rtl/me_stall_mem.sv | 119 +++++++++++
 tb/tb_me_stall_mem.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/me_stall_mem_pkg.sv
// me_stall_mem_pkg: shared state encoding and latency limits for the stalling ME-stage memory.
package me_stall_mem_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
    localparam int LAT_MAX = 15;
    localparam int CNT_W = $clog2(LAT_MAX + 1);
endpackage

// File: rtl/me_stall_mem_ram.sv
// me_ram: 2^AW x 32 word storage, synchronous write, asynchronous read on one shared address.
module me_ram #(
    parameter int AW = 8
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [0:(1<<AW)-1];
    always_ff @(posedge clock)
        if (we) mem[addr] <= wdata;
    assign rdata = mem[addr];
endmodule

// File: rtl/me_stall_mem.sv
// me_stall_mem: ME-stage data memory that stalls the pipeline LAT cycles per access.
// Define ME_LINEBUF_EN to add a one-entry read buffer that lets repeated loads hit without stalling.
module me_stall_mem
    import me_stall_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8,
    parameter int LAT        = 3
) (
    input  logic        clock,
    input  logic        reset_0,
    input  logic [31:0] addr,
    input  logic        rmem,
    input  logic        wmem,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall_me
);
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [DEPTH_LOG2-1:0] idx, idx_q, a_idx;
    logic [31:0] wdata_q, rdata_q, a_wd, ram_rd, rdata_c, lb_rd;
    logic st_q, rd_q, a_st, a_rd, req, hit, start, fire, stall_c, unused;

    assign idx    = addr[DEPTH_LOG2+1:2];
    assign unused = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};
    assign req    = rmem | wmem;
    assign start  = state == IDLE && req && !hit;
    // The IDLE request cycle is the first stall cycle, so BUSY lasts LAT-1 cycles (none when LAT is 1).
    assign fire   = (state == BUSY && cnt == CNT_W'(1)) || (start && LAT == 1);
    assign a_idx  = state == IDLE ? idx   : idx_q;
    assign a_wd   = state == IDLE ? wdata : wdata_q;
    assign a_st   = state == IDLE ? wmem  : st_q;
    assign a_rd   = state == IDLE ? rmem  : rd_q;

    me_ram #(.AW(DEPTH_LOG2)) u_ram (
        .clock (clock),
        .we    (fire && a_st),
        .addr  (a_idx),
        .wdata (a_wd),
        .rdata (ram_rd)
    );

`ifdef ME_LINEBUF_EN
    logic lb_valid;
    logic [DEPTH_LOG2-1:0] lb_tag;
    logic [31:0] lb_data;
    assign hit   = state == IDLE && rmem && !wmem && lb_valid && lb_tag == idx;
    assign lb_rd = lb_data;
    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            lb_valid <= 1'b0;
            lb_tag   <= '0;
            lb_data  <= '0;
        end else if (fire) begin
            if (!a_st) begin
                lb_valid <= 1'b1;
                lb_tag   <= a_idx;
                lb_data  <= ram_rd;
            end else if (lb_valid && lb_tag == a_idx) begin
                lb_data  <= a_wd;
            end
        end
    end
`else
    assign hit   = 1'b0;
    assign lb_rd = '0;
`endif

    always_comb begin
        state_nx = state;
        stall_c  = 1'b0;
        rdata_c  = '0;
        case (state)
            IDLE: begin
                stall_c  = start;
                rdata_c  = hit ? lb_rd : '0;
                state_nx = fire ? DONE : start ? BUSY : IDLE;
            end
            BUSY: begin
                stall_c  = 1'b1;
                state_nx = fire ? DONE : BUSY;
            end
            DONE: begin
                rdata_c  = rdata_q;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            state   <= IDLE;
            cnt     <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            st_q    <= 1'b0;
            rd_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= state_nx;
            if (start) begin
                cnt     <= CNT_W'(LAT - 1);
                idx_q   <= idx;
                wdata_q <= wdata;
                st_q    <= wmem;
                rd_q    <= rmem;
            end else if (state == BUSY) begin
                cnt <= cnt - CNT_W'(1);
            end
            // A combined read+write is a store that echoes its data; a plain store returns 0.
            if (fire) rdata_q <= a_st ? (a_rd ? a_wd : '0) : ram_rd;
        end
    end

    // Reset must silence the outputs immediately even while a request is presented.
    assign stall_me = reset_0 && stall_c;
    assign rdata    = reset_0 ? rdata_c : '0;
endmodule

// File: tb/tb_me_stall_mem.sv
// tb_me_stall_mem: randomized transaction-level check of me_stall_mem against a word-array model.
module tb_me_stall_mem;
    localparam int LAT = 3;
    localparam int DL  = 8;

    logic        clock = 1'b0;
    logic        reset_0 = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic        rmem = 1'b0, wmem = 1'b0;
    logic [31:0] rdata;
    logic        stall_me;

    me_stall_mem #(.DEPTH_LOG2(DL), .LAT(LAT)) dut (
        .clock    (clock),
        .reset_0  (reset_0),
        .addr     (addr),
        .rmem     (rmem),
        .wmem     (wmem),
        .wdata    (wdata),
        .rdata    (rdata),
        .stall_me (stall_me)
    );

    always #5 clock = ~clock;

    int checks = 0, errors = 0;
    logic        chk_en = 1'b0;
    logic        exp_stall = 1'b0;
    logic [31:0] exp_rdata = '0;
    logic [31:0] mem_m [0:255];
    logic        lb_v = 1'b0;
    logic [7:0]  lb_tag = '0;
    logic [31:0] lb_data = '0;
    int          obs_stalls = 0;
    logic [31:0] done_rdata = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            check("stall_me", {31'b0, stall_me}, {31'b0, exp_stall});
            check("rdata", rdata, exp_rdata);
            if (stall_me) obs_stalls++;
        end
    end

    task automatic next_cycle;
        @(posedge clock);
        #1;
    endtask

    task automatic scramble;
        rmem  = 1'($urandom);
        wmem  = 1'($urandom);
        addr  = $urandom;
        wdata = $urandom;
    endtask

    task automatic idle;
        rmem = 1'b0; wmem = 1'b0; addr = $urandom; wdata = $urandom;
        exp_stall = 1'b0; exp_rdata = '0;
        next_cycle;
    endtask

    // One complete access from its IDLE cycle through DONE; leaves the bench at the next IDLE cycle.
    task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        logic [7:0]  i;
        logic [31:0] res;
        i = a[9:2];
        rmem = r; wmem = w; addr = a; wdata = d;
        obs_stalls = 0;
`ifdef ME_LINEBUF_EN
        if (r && !w && lb_v && lb_tag == i) begin
            exp_stall = 1'b0; exp_rdata = lb_data;
            #3 done_rdata = rdata;
            next_cycle;
            rmem = 1'b0; wmem = 1'b0;
            return;
        end
`endif
        for (int k = 0; k < LAT; k++) begin
            exp_stall = 1'b1; exp_rdata = '0;
            next_cycle;
            scramble;
        end
        if (w) mem_m[i] = d;
        res = w ? (r ? d : 32'h0) : mem_m[i];
        if (!w) begin
            lb_v = 1'b1; lb_tag = i; lb_data = res;
        end else if (lb_v && lb_tag == i) begin
            lb_data = d;
        end
        exp_stall = 1'b0; exp_rdata = res;
        #3 done_rdata = rdata;
        next_cycle;
        rmem = 1'b0; wmem = 1'b0;
    endtask

    function automatic logic [31:0] mk_addr(input int i);
        logic [31:0] a;
        a = $urandom;
        a[9:2] = 8'(i);
        return a;
    endfunction

    initial begin
        reset_0 = 1'b0;
        rmem = 1'b1; wmem = 1'b1; addr = 32'h10; wdata = 32'h1;
        repeat (2) @(posedge clock);
        #1;
        check("reset_stall", {31'b0, stall_me}, 32'h0);
        check("reset_rdata", rdata, 32'h0);
        reset_0 = 1'b1;
        rmem = 1'b0; wmem = 1'b0;
        exp_stall = 1'b0; exp_rdata = '0;
        chk_en = 1'b1;
        next_cycle;

        for (int i = 0; i <= 16; i++) access(1'b0, 1'b1, mk_addr(i), $urandom);

        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        check("store_stalls", 32'(obs_stalls), 32'd3);
        check("store_done_rdata", done_rdata, 32'h0);
        access(1'b1, 1'b0, 32'h10, 32'h0);
        check("load_stalls", 32'(obs_stalls), 32'd3);
        check("load_done_rdata", done_rdata, 32'hDEADBEEF);
        rmem = 1'b0; wmem = 1'b0;
        exp_stall = 1'b0; exp_rdata = '0;
        #3 check("idle_after_load", rdata, 32'h0);
        next_cycle;

        access(1'b1, 1'b1, 32'h20, 32'h12345678);
        check("both_done_rdata", done_rdata, 32'h12345678);
        access(1'b1, 1'b0, 32'h20, 32'h0);
        check("both_stored", done_rdata, 32'h12345678);

        access(1'b0, 1'b1, 32'h30, 32'h11);
        rmem = 1'b0; wmem = 1'b1; addr = 32'h30; wdata = 32'h55;
        exp_stall = 1'b1; exp_rdata = '0;
        next_cycle;
        scramble;
        next_cycle;
        scramble;
        #2 chk_en = 1'b0;
        reset_0 = 1'b0;
        #1;
        check("midbusy_reset_stall", {31'b0, stall_me}, 32'h0);
        check("midbusy_reset_rdata", rdata, 32'h0);
        next_cycle;
        reset_0 = 1'b1;
        lb_v = 1'b0;
        rmem = 1'b0; wmem = 1'b0;
        exp_stall = 1'b0; exp_rdata = '0;
        chk_en = 1'b1;
        next_cycle;
        access(1'b1, 1'b0, 32'h30, 32'h0);
        check("store_discarded", done_rdata, 32'h11);

        access(1'b0, 1'b1, 32'h401, 32'hA5A50001);
        access(1'b1, 1'b0, 32'h0, 32'h0);
        check("alias_word0", done_rdata, 32'hA5A50001);

`ifdef ME_LINEBUF_EN
        access(1'b1, 1'b0, 32'h40, 32'h0);
        check("lb_miss_stalls", 32'(obs_stalls), 32'd3);
        access(1'b1, 1'b0, 32'h40, 32'h0);
        check("lb_hit_stalls", 32'(obs_stalls), 32'd0);
        access(1'b0, 1'b1, 32'h40, 32'h99);
        access(1'b1, 1'b0, 32'h40, 32'h0);
        check("lb_update_stalls", 32'(obs_stalls), 32'd0);
        check("lb_update_rdata", done_rdata, 32'h99);
`endif

        for (int n = 0; n < 300; n++) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            if (kind == 0) idle;
            else access(1'(kind != 2 ? 1 : 0), 1'(kind >= 2 ? 1 : 0), mk_addr(int'($urandom_range(0, 16))), $urandom);
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
